// File: rtl/alu_share_ctrl_if.sv
// Bundle of requester, ALU and response signals between issue logic, the
// shared-ALU controller and the ALU instance.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 13,
  parameter int OP_W  = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_result;
  logic             alu_beq;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_beq;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_beq, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_in1, alu_in2,
    output rsp_valid, rsp_id, rsp_result, rsp_beq, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_beq, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_in1, alu_in2,
    input  rsp_valid, rsp_id, rsp_result, rsp_beq, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin share of one ALU between two requesters: grant, hold operands
// for EXEC_CYCLES, then present the tagged result until the consumer takes it.
module alu_share_ctrl #(
  parameter int WIDTH       = 13,
  parameter int OP_W        = 3,
  parameter int EXEC_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_share_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]      EXEC_INIT = 4'(EXEC_CYCLES);
  localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(3'b101);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_beq_q, rsp_beq_d;
  logic             grant0, grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ptr_q        <= 1'b0;
      alu_op_q     <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_beq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      alu_op_q     <= alu_op_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_beq_q    <= rsp_beq_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    alu_op_d     = alu_op_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_beq_d    = rsp_beq_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A lone valid wins outright; the pointer only breaks ties.
        if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
          grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0) begin
          alu_op_d  = bus.req0_op;
          alu_in1_d = bus.req0_a;
          alu_in2_d = bus.req0_b;
          rsp_id_d  = 1'b0;
          cnt_d     = EXEC_INIT;
          state_d   = ST_EXEC;
        end else if (grant1) begin
          alu_op_d  = bus.req1_op;
          alu_in1_d = bus.req1_a;
          alu_in2_d = bus.req1_b;
          rsp_id_d  = 1'b1;
          cnt_d     = EXEC_INIT;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_result_d = bus.alu_result;
          rsp_beq_d    = (alu_op_q == OP_BEQ) & bus.alu_beq;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_beq    = rsp_beq_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (EXEC_CYCLES 1 and 3) behind a
// select mux, a toy ALU, and a transaction-level model of grant and response.
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(13), .OP_W(3)) ifa ();
  alu_share_ctrl_if #(.WIDTH(13), .OP_W(3)) ifb ();

  alu_share_ctrl #(.WIDTH(13), .OP_W(3), .EXEC_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  alu_share_ctrl #(.WIDTH(13), .OP_W(3), .EXEC_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  function automatic logic [12:0] alu_f(input logic [2:0] op, input logic [12:0] a, input logic [12:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a - b;
      3'b110:  return a + b;
      default: return a;
    endcase
  endfunction

  logic        sel, v0, v1, rr;
  logic [2:0]  op0, op1;
  logic [12:0] a0, b0, a1, b1;

  assign ifa.req0_valid = v0 & ~sel;
  assign ifa.req1_valid = v1 & ~sel;
  assign ifb.req0_valid = v0 & sel;
  assign ifb.req1_valid = v1 & sel;
  assign ifa.req0_op = op0;  assign ifb.req0_op = op0;
  assign ifa.req0_a  = a0;   assign ifb.req0_a  = a0;
  assign ifa.req0_b  = b0;   assign ifb.req0_b  = b0;
  assign ifa.req1_op = op1;  assign ifb.req1_op = op1;
  assign ifa.req1_a  = a1;   assign ifb.req1_a  = a1;
  assign ifa.req1_b  = b1;   assign ifb.req1_b  = b1;
  assign ifa.rsp_ready = rr;
  assign ifb.rsp_ready = rr;
  assign ifa.alu_result = alu_f(ifa.alu_op, ifa.alu_in1, ifa.alu_in2);
  assign ifa.alu_beq    = (ifa.alu_in1 == ifa.alu_in2);
  assign ifb.alu_result = alu_f(ifb.alu_op, ifb.alu_in1, ifb.alu_in2);
  assign ifb.alu_beq    = (ifb.alu_in1 == ifb.alu_in2);

  logic        o_r0, o_r1, o_busy, o_rv, o_id, o_beq;
  logic [2:0]  o_op;
  logic [12:0] o_in1, o_in2, o_res;
  assign o_r0   = sel ? ifb.req0_ready : ifa.req0_ready;
  assign o_r1   = sel ? ifb.req1_ready : ifa.req1_ready;
  assign o_busy = sel ? ifb.busy       : ifa.busy;
  assign o_rv   = sel ? ifb.rsp_valid  : ifa.rsp_valid;
  assign o_id   = sel ? ifb.rsp_id     : ifa.rsp_id;
  assign o_beq  = sel ? ifb.rsp_beq    : ifa.rsp_beq;
  assign o_op   = sel ? ifb.alu_op     : ifa.alu_op;
  assign o_in1  = sel ? ifb.alu_in1    : ifa.alu_in1;
  assign o_in2  = sel ? ifb.alu_in2    : ifa.alu_in2;
  assign o_res  = sel ? ifb.rsp_result : ifa.rsp_result;

  int checks = 0;
  int errors = 0;
  bit ptr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},  32'(o_busy), 32'd0);
    chk({tag, ".rv"},    32'(o_rv),   32'd0);
    chk({tag, ".ready"}, 32'({o_r0, o_r1}), 32'd0);
    chk({tag, ".alu"},   32'({o_op, o_in1, o_in2}), 32'd0);
    chk({tag, ".rsp"},   32'({o_id, o_beq, o_res}), 32'd0);
  endtask

  // One full transaction on instance s; model predicts grant, data and latency.
  task automatic do_op(input bit s, input bit rv0, input bit rv1,
                       input logic [2:0] p0, input logic [12:0] x0, input logic [12:0] y0,
                       input logic [2:0] p1, input logic [12:0] x1, input logic [12:0] y1,
                       input int hold);
    bit          g;
    int          ec, lat;
    logic [2:0]  eop;
    logic [12:0] ea, eb, eres;
    logic        ebeq;
    ec = s ? 3 : 1;
    @(negedge clk);
    sel = s; v0 = rv0; v1 = rv1;
    op0 = p0; a0 = x0; b0 = y0; op1 = p1; a1 = x1; b1 = y1;
    g    = (rv0 && rv1) ? ptr[s] : rv1;
    eop  = g ? p1 : p0;
    ea   = g ? x1 : x0;
    eb   = g ? y1 : y0;
    eres = alu_f(eop, ea, eb);
    ebeq = (eop == 3'b101) && (ea == eb);
    #1;
    chk("grant", 32'({o_r0, o_r1}), g ? 32'd1 : 32'd2);
    chk("idle_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1;
    op0 = 3'($urandom); a0 = 13'($urandom); b0 = 13'($urandom);
    op1 = 3'($urandom); a1 = 13'($urandom); b1 = 13'($urandom);
    #1;
    chk("latched", 32'({o_op, o_in1, o_in2}), 32'({eop, ea, eb}));
    chk("exec_ready", 32'({o_r0, o_r1, o_busy}), 32'd1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_rv === 1'b1) break;
    end
    chk("latency", 32'(lat), 32'(ec));
    chk("rsp", 32'({o_id, o_beq, o_res}), 32'({g, ebeq, eres}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_rsp", 32'({o_rv, o_id, o_beq, o_res}), 32'({1'b1, g, ebeq, eres}));
      chk("stall_ready", 32'({o_r0, o_r1, o_busy}), 32'd1);
    end
    v0 = 1'b0; v1 = 1'b0;
    rr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr = 1'b0;
    ptr[s] = ~g;
    chk("release", 32'({o_rv, o_busy}), 32'd0);
    chk("alu_hold", 32'({o_op, o_in1, o_in2}), 32'({eop, ea, eb}));
  endtask

  initial begin
    #400000;
    $error("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
    ptr[0] = 1'b0; ptr[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset_a");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_a");
    sel = 1'b1; #1;
    chk_all_zero("post_reset_b");
    sel = 1'b0;

    // Tie-break from pointer 0, then the other requester gets its turn.
    do_op(0, 1, 1, 3'b001, 13'd10, 13'd3, 3'b101, 13'd9, 13'd9, 0);
    do_op(0, 1, 1, 3'b001, 13'd10, 13'd3, 3'b101, 13'd9, 13'd9, 0);
    do_op(0, 1, 0, 3'b000, 13'd5, 13'd7, 3'b000, 13'd0, 13'd0, 0);
    do_op(0, 0, 1, 3'b000, 13'd0, 13'd0, 3'b011, 13'h0f0, 13'h00f, 5);
    do_op(0, 1, 0, 3'b101, 13'd4, 13'd4, 3'b000, 13'd0, 13'd0, 1);
    do_op(1, 0, 1, 3'b000, 13'd0, 13'd0, 3'b110, 13'd8191, 13'd1, 0);
    do_op(1, 1, 1, 3'b101, 13'd77, 13'd77, 3'b001, 13'd1, 13'd2, 2);

    // Abort mid-EXEC on the 3-cycle instance.
    @(negedge clk);
    sel = 1'b1; v1 = 1'b1; op1 = 3'b000; a1 = 13'd100; b1 = 13'd23;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort_b");
    @(negedge clk);
    rst_n = 1'b1;
    ptr[0] = 1'b0; ptr[1] = 1'b0;
    rr = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'({o_rv, o_busy}), 32'd0);
    end
    rr = 1'b0;
    do_op(1, 1, 0, 3'b100, 13'h1555, 13'h0aaa, 3'b000, 13'd0, 13'd0, 0);

    for (int n = 0; n < 30; n++) begin
      bit rs, r0, r1;
      rs = 1'($urandom);
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      do_op(rs, r0, r1,
            3'($urandom), 13'($urandom), 13'($urandom_range(0, 3)),
            3'($urandom), 13'($urandom_range(0, 3)), 13'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
